// File: rtl/demux_pkg.sv
// rtl/demux_pkg.sv - shared constants, state type and select decode for the 1-to-7 write distributor
package demux_pkg;

    localparam int DATA_W = 32;
    localparam int DEST_N = 7;
    localparam int SEL_W  = 3;

    localparam logic [SEL_W-1:0] SEL_ILLEGAL = 3'd7;

    typedef enum logic {
        IDLE = 1'b0,
        PEND = 1'b1
    } state_t;

    // One-hot destination vector for a select code; code 7 maps to no destination.
    function automatic logic [DEST_N-1:0] dest_onehot(input logic [SEL_W-1:0] sel);
        logic [DEST_N-1:0] v;
        v = '0;
        for (int k = 0; k < DEST_N; k++) begin
            v[k] = (sel == SEL_W'(k));
        end
        return v;
    endfunction

endpackage

// File: rtl/demux_dest_reg.sv
// rtl/demux_dest_reg.sv - one destination holding register with its valid bit
module demux_dest_reg #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_load,
    input  logic              i_clear,
    input  logic [DATA_W-1:0] i_data,
    output logic [DATA_W-1:0] o_data,
    output logic              o_valid
);

    logic [DATA_W-1:0] r_data;
    logic              r_valid;

    // Load wins over clear so a same-edge completion plus new word keeps the slot valid.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_data  <= '0;
            r_valid <= 1'b0;
        end else if (i_load) begin
            r_data  <= i_data;
            r_valid <= 1'b1;
        end else if (i_clear) begin
            r_valid <= 1'b0;
        end
    end

    assign o_data  = r_data;
    assign o_valid = r_valid;

endmodule

// File: rtl/demux32_06_reg.sv
// rtl/demux32_06_reg.sv - registered 1-to-7 write distributor; DEMUX32_06_ERR_EN enables the sticky illegal-select flag
module demux32_06_reg #(
    parameter int DATA_W = demux_pkg::DATA_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        signal,
    input  logic [DATA_W-1:0] data_In,
    output logic [DATA_W-1:0] data_0,
    output logic [DATA_W-1:0] data_1,
    output logic [DATA_W-1:0] data_2,
    output logic [DATA_W-1:0] data_3,
    output logic [DATA_W-1:0] data_4,
    output logic [DATA_W-1:0] data_5,
    output logic [DATA_W-1:0] data_6,
    output logic [6:0]        out_valid,
    input  logic [6:0]        out_ready,
    output logic              err
);

    import demux_pkg::*;

    state_t            r_state;
    state_t            w_state_next;
    logic [DATA_W-1:0] w_data [DEST_N];
    logic [DEST_N-1:0] w_load;
    logic [DEST_N-1:0] w_clear;
    logic [DEST_N-1:0] w_valid;
    logic              w_accept;
    logic              w_complete;
    logic              w_sel_illegal;

    // Only the pending slot can have a valid bit, so any ready&valid overlap is its completion.
    assign w_complete    = |(w_valid & out_ready);
    assign in_ready      = !reset && ((r_state == IDLE) || w_complete);
    assign w_accept      = in_valid && in_ready;
    assign w_sel_illegal = (signal == SEL_ILLEGAL);
    assign w_clear       = w_valid & out_ready;

`ifdef DEMUX32_06_ERR_EN
    logic r_err;

    // Illegal code consumes the offer without touching any destination.
    assign w_load = (w_accept && !w_sel_illegal) ? dest_onehot(signal) : '0;

    // Sticky flag, cleared only by reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_err <= 1'b0;
        end else if (w_accept && w_sel_illegal) begin
            r_err <= 1'b1;
        end
    end

    assign err = r_err;
`else
    logic [SEL_W-1:0] w_sel;

    // Code 7 aliases onto the last destination, mirroring the read-side select mux.
    assign w_sel  = w_sel_illegal ? SEL_W'(DEST_N - 1) : signal;
    assign w_load = w_accept ? dest_onehot(w_sel) : '0;
    assign err    = 1'b0;
`endif

    // State register: pending vs idle tracks whether any slot holds an unconsumed word.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next state: a load always leaves us pending; a bare completion returns to idle.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE: begin
                if (|w_load) begin
                    w_state_next = PEND;
                end
            end
            PEND: begin
                if (|w_load) begin
                    w_state_next = PEND;
                end else if (w_complete) begin
                    w_state_next = IDLE;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    for (genvar k = 0; k < DEST_N; k++) begin : g_dest
        demux_dest_reg #(
            .DATA_W (DATA_W)
        ) u_dest_reg (
            .clk     (clk),
            .reset   (reset),
            .i_load  (w_load[k]),
            .i_clear (w_clear[k]),
            .i_data  (data_In),
            .o_data  (w_data[k]),
            .o_valid (w_valid[k])
        );
    end

    assign data_0    = w_data[0];
    assign data_1    = w_data[1];
    assign data_2    = w_data[2];
    assign data_3    = w_data[3];
    assign data_4    = w_data[4];
    assign data_5    = w_data[5];
    assign data_6    = w_data[6];
    assign out_valid = w_valid;

endmodule

// File: doc/demux32_06_reg.md
# demux32_06_reg

Registered 1-to-7 write distributor for 32-bit datapath values: the write-side counterpart of the 7-input datapath select mux. It accepts one word plus a 3-bit destination code per transaction, latches the word into the selected destination holding register, and presents it with a per-destination valid/ready handshake. It sits between control-unit-steered producers (ALU result, memory data, shifter) and up to seven consumer registers that load at different times.

## Interface
Parameters:
- DATA_W, 32, word width
- DEST_N, 7, number of destinations (fixed; encoded 0..6 on a 3-bit select)

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  synchronous, active-high
- in_valid  in  1  producer offers a word
- in_ready  out  1  block can accept this cycle
- signal  in  3  destination code, 0..6 (000..110)
- data_In  in  32  word to distribute
- data_0 … data_6  out  32 each  destination holding registers
- out_valid  out  7  one-hot: bit k = data_k holds an unconsumed word
- out_ready  in  7  bit k = consumer k takes data_k this cycle
- err  out  1  sticky illegal-select flag

## Operation
- Accept: `in_valid && in_ready` at a rising edge.
- On accept with signal = k (0..6): data_k <= data_In; out_valid[k] <= 1. Other data_j retain their value.
- Pending state: out_valid nonzero (at most one bit set). Two states: IDLE (out_valid = 0) and PEND(k).
- in_ready = !reset && (out_valid == 0 || out_ready[k_pending]). Back-to-back transfers allowed.
- Complete: in PEND(k), out_ready[k] = 1 -> out_valid[k] <= 0 unless a new accept occurs the same edge.
- Simultaneous completion + accept: new word wins; out_valid becomes one-hot for the new destination (same or different k). If same k, data_k overwritten, out_valid[k] stays 1.
- out_ready[j] for j not pending: ignored.
- data_k is never cleared except by reset; consumers may read it at any time.
- Illegal signal = 7: see Configuration.
- Reset mid-transfer: pending word discarded, out_valid = 0, no completion reported.

## Timing
- Reset values: data_0..data_6 = 0, out_valid = 0, err = 0, in_ready = 0 while reset high.
- Latency: accept at edge N -> data_k and out_valid[k] valid after edge N (visible in cycle N+1).
- Throughput: 1 word/cycle when consumer holds out_ready[k] high.
- in_ready is combinational from out_valid and out_ready; no other comb paths input->output.
- data_In and signal sampled only on accept edges.

## Configuration
- DEMUX32_06_ERR_EN defined: signal = 7 with in_valid accepted (consumes the offer, in_ready unaffected), no data_k written, no out_valid set, err <= 1 and held until reset.
- Undefined: signal = 7 aliases to destination 6 (matches the select mux, where 11x chooses input 6); err tied to 0.

## Structure
- Package demux_pkg: DEST_N = 7, SEL_W = 3, SEL_ILLEGAL = 3'd7, DATA_W = 32, state enum {IDLE, PEND}.
- One sub-module: demux_dest_reg (one holding register + valid bit with load/clear), instantiated 7 times; top holds select decode, in_ready logic, err.

## Test plan
- Reset: hold reset 2 cycles with in_valid=1 -> in_ready=0, all data_k=0, out_valid=0, err=0.
- Single write: signal=3, data_In=32'hDEADBEEF, out_ready=0 -> data_3=DEADBEEF, out_valid=7'b0001000, in_ready=0 until out_ready[3]=1, then out_valid=0.
- Streaming: out_ready=7'h7F, signals 0,1,…,6 with data 1..7 on consecutive cycles -> data_k=k+1, one accept per cycle, out_valid one-hot following signal each cycle.
- Same-edge complete+accept: PEND(2), out_ready[2]=1, new word 32'h5 to signal=2 -> data_2=5, out_valid[2] stays 1; repeat to signal=5 -> out_valid=7'b0100000.
- Illegal select, ERR_EN defined: signal=7, data 32'hAAAA -> no data_k change, out_valid=0, err=1 sticky; undefined: data_6=32'hAAAA, out_valid[6]=1, err=0.
- Reset mid-transfer: PEND(4) then reset -> out_valid=0, data_4=0, a later out_ready[4] pulse has no effect.
